// File: rtl/arb_pkg.sv
// Shared types and helpers for the four-requester round-robin arbiter.
// Holds the FSM state encoding, requester count and one-hot decode.
package arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    // Encoder for a one-hot (or zero) 4-bit vector; zero maps to index 0.
    function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
        onehot_to_idx = {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/arb_rr4_pick.sv
// rr_pick4: combinational round-robin pick of one request.
// Ports: req[3:0], ptr[1:0] (highest-priority index) -> gnt[3:0] one-hot, any.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] gnt,
    output logic       any
);

    logic [7:0] rot_w;
    logic [3:0] rot;
    logic [3:0] pk;
    logic [7:0] back_w;

    // Rotate so ptr lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        rot_w  = {req, req} >> ptr;
        rot    = rot_w[3:0];
        pk     = rot & (~rot + 4'd1);
        back_w = {pk, pk} << ptr;
        gnt    = back_w[7:4];
        any    = |req;
    end

endmodule

// File: rtl/arb_rr4.sv
// arb_rr4: four-requester round-robin arbiter with packet locking.
// Ports: clk, reset (async, active-high); in_valid/in_last/in_ready[3:0]
// per requester; out_valid/out_last/out_ready to the consumer;
// grant[3:0] one-hot mux select (zero when idle); busy.
module arb_rr4
    import arb_pkg::*;
#(
    parameter int MAXB = 16,
    parameter int CW   = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_valid,
    input  logic [3:0] in_last,
    output logic [3:0] in_ready,
    output logic       out_valid,
    output logic       out_last,
    input  logic       out_ready,
    output logic [3:0] grant,
    output logic       busy
);

    localparam logic [CW-1:0] CLIM = CW'(MAXB - 1);

    arb_state_t    state_q, state_d;
    logic [3:0]    grant_d;
    logic [1:0]    ptr, ptr_d, ptr_nxt;
    logic [CW-1:0] cnt, cnt_d;
    logic [3:0]    pick_req, pick_gnt;
    logic [1:0]    pick_ptr;
    logic          pick_any;
    logic          xfer;

    // One picker serves both the idle arbitration and the
    // zero-bubble handover, which excludes the outgoing owner.
    assign ptr_nxt  = onehot_to_idx(grant) + 2'd1;
    assign pick_req = busy ? (in_valid & ~grant) : in_valid;
    assign pick_ptr = busy ? ptr_nxt : ptr;

    rr_pick4 u_pick (
        .req (pick_req),
        .ptr (pick_ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    assign busy      = (state_q == ARB_BUSY);
    assign out_valid = |(grant & in_valid);
    assign in_ready  = grant & {4{out_ready}};
    assign out_last  = busy & ((|(grant & in_last)) | (cnt == CLIM));
    assign xfer      = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        grant_d = grant;
        ptr_d   = ptr;
        cnt_d   = cnt;
        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grant_d = pick_gnt;
                    cnt_d   = '0;
                    state_d = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                if (xfer) begin
                    if (out_last) begin
                        ptr_d = ptr_nxt;
                        cnt_d = '0;
                        if (pick_any) begin
                            grant_d = pick_gnt;
                        end else begin
                            grant_d = '0;
                            state_d = ARB_IDLE;
                        end
                    end else begin
                        cnt_d = cnt + CW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ARB_IDLE;
            grant   <= '0;
            ptr     <= '0;
            cnt     <= '0;
        end else begin
            state_q <= state_d;
            grant   <= grant_d;
            ptr     <= ptr_d;
            cnt     <= cnt_d;
        end
    end

endmodule

// File: tb/tb_arb_rr4.sv
// Self-checking bench for arb_rr4 (MAXB=4): directed scenarios plus
// randomized traffic compared against an owner/pointer/count model.
module tb_arb_rr4;

    localparam int MAXB = 4;
    localparam int CW   = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_valid = '0;
    logic [3:0] in_last = '0;
    logic [3:0] in_ready;
    logic       out_valid;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic [3:0] grant;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: owner index (-1 = nobody), priority pointer, beats taken.
    int m_own = -1;
    int m_ptr = 0;
    int m_cnt = 0;

    arb_rr4 #(.MAXB(MAXB), .CW(CW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [3:0] req, input int p);
        for (int k = 0; k < 4; k++) begin
            if (req[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] own_mask(input int own);
        logic [3:0] m;
        m = '0;
        if (own >= 0) m[own] = 1'b1;
        return m;
    endfunction

    function automatic logic m_last(input int own, input int cnt,
                                    input logic [3:0] l);
        if (own < 0) return 1'b0;
        return l[own] || (cnt == MAXB - 1);
    endfunction

    function automatic void m_next(input int own, input int p, input int cnt,
                                   input logic [3:0] v, input logic [3:0] l,
                                   input logic r,
                                   output int no, output int np,
                                   output int nc);
        no = own;
        np = p;
        nc = cnt;
        if (own < 0) begin
            no = pick(v, p);
            nc = 0;
        end else if (v[own] && r) begin
            if (m_last(own, cnt, l)) begin
                np = (own + 1) % 4;
                nc = 0;
                no = pick(v & ~own_mask(own), np);
            end else begin
                nc = cnt + 1;
            end
        end
    endfunction

    always @(posedge clk or posedge reset) begin
        int no, np, nc;
        if (reset) begin
            m_own <= -1;
            m_ptr <= 0;
            m_cnt <= 0;
        end else begin
            m_next(m_own, m_ptr, m_cnt, in_valid, in_last, out_ready,
                   no, np, nc);
            m_own <= no;
            m_ptr <= np;
            m_cnt <= nc;
        end
    end

    task automatic compare();
        logic [3:0] g;
        g = own_mask(m_own);
        chk("grant", grant, g);
        chk("busy", busy, m_own >= 0);
        chk("out_valid", out_valid, |(g & in_valid));
        chk("in_ready", in_ready, out_ready ? g : 4'b0);
        chk("out_last", out_last, m_last(m_own, m_cnt, in_last));
        chk("onehot0", $onehot0(grant), 1);
    endtask

    task automatic cyc(input logic [3:0] v, input logic [3:0] l,
                       input logic r);
        @(negedge clk);
        in_valid  = v;
        in_last   = l;
        out_ready = r;
        #1;
        compare();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        in_valid = '0;
        in_last = '0;
        out_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single requester 2, single beat: grant, then back to idle.
        cyc(4'b0100, 4'b0100, 1'b1);
        chk("s1_lat", grant, 4'b0000);
        cyc(4'b0100, 4'b0100, 1'b1);
        chk("s1_gnt", grant, 4'b0100);
        chk("s1_last", out_last, 1'b1);
        chk("s1_rdy", in_ready, 4'b0100);
        cyc(4'b1111, 4'b1111, 1'b1);
        chk("s1_idle", busy, 1'b0);
        cyc(4'b1111, 4'b1111, 1'b1);
        chk("s1_ptr3", grant, 4'b1000);

        // All valid, single-beat packets: strict rotation, no bubble.
        do_reset();
        cyc(4'b1111, 4'b1111, 1'b1);
        for (int i = 0; i < 5; i++) begin
            logic [3:0] e;
            e = 4'b0001 << (i % 4);
            cyc(4'b1111, 4'b1111, 1'b1);
            chk("s2_rot", grant, e);
        end

        // Requester 1 sends a 3-beat packet while others request.
        do_reset();
        cyc(4'b0010, 4'b0000, 1'b1);
        cyc(4'b1111, 4'b0000, 1'b1);
        chk("s3_b1", {grant, out_last}, {4'b0010, 1'b0});
        cyc(4'b1111, 4'b0000, 1'b1);
        chk("s3_b2", {grant, out_last}, {4'b0010, 1'b0});
        cyc(4'b1111, 4'b0010, 1'b1);
        chk("s3_b3", {grant, out_last}, {4'b0010, 1'b1});
        cyc(4'b1111, 4'b0000, 1'b1);
        chk("s3_next", grant, 4'b0100);

        // Burst limit: requester 0 never sends last, requester 3 waits.
        do_reset();
        cyc(4'b0001, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc(4'b1001, 4'b0000, 1'b1);
            chk("s4_hold", grant, 4'b0001);
            chk("s4_lim", out_last, i == 3);
        end
        cyc(4'b1001, 4'b1000, 1'b1);
        chk("s4_g3", grant, 4'b1000);
        cyc(4'b1001, 4'b0000, 1'b1);
        chk("s4_back", grant, 4'b0001);

        // Stall and valid drop mid-packet freeze the beat count.
        do_reset();
        cyc(4'b0100, 4'b0000, 1'b1);
        cyc(4'b0100, 4'b0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cyc(4'b0100, 4'b0000, 1'b0);
            chk("s5_stall", {grant, in_ready}, {4'b0100, 4'b0000});
        end
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0000, 4'b0000, 1'b1);
            chk("s5_drop", {grant, out_valid}, {4'b0100, 1'b0});
        end
        cyc(4'b0100, 4'b0000, 1'b1);
        cyc(4'b0100, 4'b0000, 1'b1);
        chk("s5_b3", out_last, 1'b0);
        cyc(4'b0100, 4'b0000, 1'b1);
        chk("s5_b4", out_last, 1'b1);

        // Reset during beat 2 of a packet.
        do_reset();
        cyc(4'b0101, 4'b0000, 1'b1);
        cyc(4'b0101, 4'b0000, 1'b1);
        cyc(4'b0101, 4'b0000, 1'b1);
        reset = 1'b1;
        #1;
        chk("s6_rst", {grant, out_valid, busy}, {4'b0000, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        cyc(4'b1111, 4'b0000, 1'b1);
        cyc(4'b1111, 4'b0000, 1'b1);
        chk("s6_from0", grant, 4'b0001);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            logic [3:0] v, l;
            for (int b = 0; b < 4; b++) begin
                v[b] = ($urandom_range(0, 3) != 0);
                l[b] = ($urandom_range(0, 2) == 0);
            end
            cyc(v, l, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/arb_rr4.md
Name: arb_rr4

Overview:
- Four-requester round-robin arbiter with packet locking.
- Shares one mux4 datapath between four beat-streaming requesters.
- Drives registered one-hot grant[3:0] straight into mux4 sel3..sel0; grant is never multi-hot, so the mux4 simulation error check never fires.
- Handshakes beats through to a single downstream consumer and rotates priority at packet end or at a fairness burst limit.

Parameters:
- MAXB, 16, max beats per grant before forced release (1..2^CW)
- CW, 5, width of beat counter

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  4  per-requester beat valid
- in_last  in  4  per-requester last-beat-of-packet flag
- in_ready  out  4  per-requester beat accepted
- out_valid  out  1  muxed beat valid to consumer
- out_last  out  1  end of grant (packet last or burst limit)
- out_ready  in  1  consumer accepts beat
- grant  out  4  one-hot select to mux4 {sel3,sel2,sel1,sel0}; all-zero when idle
- busy  out  1  state==BUSY

Behaviour:
- Reset (async): state=IDLE, grant=0, ptr=0 (requester 0 highest priority), cnt=0. This forces out_valid=0, in_ready=0, out_last=0, busy=0.
- IDLE:
  - If any in_valid is high, next edge sets grant=onehot(first i at or after ptr, cyclic over in_valid), cnt=0, state=BUSY.
  - Arbitration latency is one cycle; grant only changes on a clock edge.
- BUSY, combinational outputs:
  - out_valid = |(grant & in_valid)
  - in_ready = grant & {4{out_ready}}
  - out_last = |(grant & in_last) | (cnt==MAXB-1)
- xfer = out_valid & out_ready.
- xfer without end: cnt++; grant held.
- xfer with end (out_last high):
  - ptr = index(grant)+1 mod 4.
  - cnt=0.
  - others = in_valid & ~grant.
  - If others is non-zero, grant=onehot(pick(others, new ptr)) on the same edge; state stays BUSY (zero-bubble handover).
  - Otherwise grant=0 and state=IDLE. The ex-owner re-arbitrates from IDLE with one bubble.
- Granted requester drops in_valid mid-packet: grant held, cnt frozen, no timeout. The owner keeps the lock until its end beat.
- out_ready low: everything held. in_valid/in_last of the granted requester must stay stable until ready (producer rule, not checked).
- Non-granted requesters: in_ready=0 always; their valid/last are ignored except for arbitration.
- Burst limit: on the MAXB-th accepted beat, out_last=1 even if in_last=0. The requester loses the grant and resumes its packet when next granted.
- MAXB=1: every beat ends the grant, giving strict beat-level round robin.
- Invariant: $onehot0(grant) every cycle; grant!=0 iff busy.
- Reset asserted mid-packet: immediate return to the reset state. The partial packet is dropped from the arbiter's view.

Decomposition:
- Package arb_pkg:
  - state encoding constants (ARB_IDLE=1'b0, ARB_BUSY=1'b1)
  - N_REQ=4
  - function onehot_to_idx(4-bit)→2-bit
- Sub-module rr_pick4: combinational.
  - Inputs req[3:0], ptr[1:0]; outputs gnt[3:0] one-hot, any.
  - Rotates req right by ptr, does fixed priority-pick, rotates back.
  - Instantiated once for the IDLE path and once for the handover path (others), or shared via an input mux.

Test Plan:
- Reset then in_valid=4'b0100, in_last=4'b0100, out_ready=1 → cycle+1 grant=4'b0100, out_valid=1, out_last=1, in_ready=4'b0100; next edge grant=0, busy=0, ptr=3.
- All four valid continuously, single-beat packets (in_last=4'b1111), out_ready=1 → grant sequence 0001,0010,0100,1000,0001; no idle bubble between grants; onehot0 holds throughout.
- Requester 1 sends a 3-beat packet while 0/2/3 request → grant stays 4'b0010 for exactly 3 xfers; out_last only on beat 3; then grant=4'b0100.
- MAXB=4, requester 0 sends 10 beats with in_last=0 and requester 3 valid → grant moves 0001→1000 after 4 xfers with out_last=1; returns to 0001 after 3's packet ends.
- out_ready=0 for 5 cycles mid-packet, and requester 2 drops in_valid for 3 cycles mid-packet → grant unchanged, cnt unchanged, in_ready=0 (stall) / out_valid=0 (drop); resumes correctly.
- Assert reset during beat 2 of a 4-beat packet → same cycle grant=0, out_valid=0, busy=0; after release, arbitration starts from requester 0.
